// File: rtl/edit_mem_pkg.sv
// Shared definitions for the edit-memory free-buffer arbiter: FSM state codes,
// default pool response latency and requester-id width helper.
package edit_mem_pkg;

  localparam logic [2:0] ST_WAIT_DONE  = 3'd0;
  localparam logic [2:0] ST_RUN        = 3'd1;
  localparam logic [2:0] ST_DRAIN      = 3'd2;
  localparam logic [2:0] ST_INIT_PULSE = 3'd3;
  localparam logic [2:0] ST_WAIT_LOW   = 3'd4;

  localparam int FREEB_LAT_DEF = 3;

  function automatic int id_nbits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edit_mem_rr_arb.sv
// N-wide round-robin arbiter: one-hot grant to the first requester at or after
// the pointer; the pointer moves just past the grantee when advance is high.
module edit_mem_rr_arb
  import edit_mem_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int PW = id_nbits(N);

  logic [PW-1:0] ptr_reg;
  logic [N-1:0]  mask;
  logic [N-1:0]  masked;
  logic [N-1:0]  pick;
  logic [PW-1:0] nxt_acc [N+1];

  assign nxt_acc[0] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      assign mask[gi]      = (PW'(gi) >= ptr_reg);
      assign nxt_acc[gi+1] = nxt_acc[gi] | (grant[gi] ? PW'((gi + 1) % N) : '0);
    end
  endgenerate

  // Requests at/above the pointer win; otherwise wrap to the lowest index.
  assign masked = req & mask;
  assign pick   = (|masked) ? masked : req;
  assign grant  = pick & (~pick + N'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (advance && (|grant)) begin
      ptr_reg <= nxt_acc[N];
    end
  end

endmodule

// File: rtl/edit_mem_freeb_arb.sv
// Shares the edit-memory free-buffer pool among NREQ processing units: allocate and
// release arbitration, in-flight tag pipe, per-requester quota and pool re-init.
module edit_mem_freeb_arb
  import edit_mem_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int BPTR_NBITS = 10,
  parameter int FREEB_LAT  = FREEB_LAT_DEF,
  parameter int QUOTA      = 16,
  parameter int QNBITS     = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  output logic [NREQ-1:0]            ack,
  output logic                       ack_ok,
  output logic [BPTR_NBITS-1:0]      ack_ptr,
  input  logic [NREQ-1:0]            rel_valid,
  input  logic [NREQ*BPTR_NBITS-1:0] rel_ptr,
  output logic [NREQ-1:0]            rel_ready,
  input  logic                       sw_init,
  output logic                       init_busy,
  output logic [NREQ-1:0]            quota_err,
  output logic                       freeb_req,
  input  logic                       freeb_resp_valid,
  input  logic                       freeb_resp_avail,
  input  logic [BPTR_NBITS-1:0]      freeb_resp_ptr,
  output logic                       freeb_rel_valid,
  output logic [BPTR_NBITS-1:0]      freeb_rel_ptr,
  output logic                       freeb_init,
  input  logic                       freeb_init_done
);
  localparam int IDW = id_nbits(NREQ);
  localparam int SW  = IDW + 1;
  localparam int PIW = FREEB_LAT * SW;

  logic [2:0]            state_reg, state_next;
  logic                  run, rel_en;
  logic [NREQ-1:0]       elig, alloc_grant, rel_grant;
  logic                  freeb_req_reg;
  logic [IDW-1:0]        req_id_reg;
  logic [PIW-1:0]        pipe_reg;
  logic [FREEB_LAT-1:0]  pipe_v;
  logic                  head_v, resp_hit;
  logic [IDW-1:0]        head_id;
  logic [IDW-1:0]        id_acc [NREQ+1];
  logic [BPTR_NBITS-1:0] ptr_acc [NREQ+1];
  logic                  freeb_rel_valid_reg;
  logic [BPTR_NBITS-1:0] freeb_rel_ptr_reg;

  assign run    = (state_reg == ST_RUN);
  assign rel_en = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);

  // Pipe stage 0 sits in the LSBs; each stage is {valid, id}.
  assign head_v   = pipe_reg[PIW-1];
  assign head_id  = pipe_reg[PIW-2 -: IDW];
  assign resp_hit = freeb_resp_valid & head_v;

  assign id_acc[0]  = '0;
  assign ptr_acc[0] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < FREEB_LAT; gi++) begin : g_pipe_v
      assign pipe_v[gi] = pipe_reg[gi*SW + IDW];
    end

    for (gi = 0; gi < NREQ; gi++) begin : g_req
      logic              pending_reg;
      logic              err_reg;
      logic [QNBITS-1:0] held_reg;
      logic              inc, dec;

      assign elig[gi]      = run & req[gi] & ~pending_reg & (held_reg < QNBITS'(QUOTA));
      assign ack[gi]       = resp_hit & (head_id == IDW'(gi));
      assign inc           = ack[gi] & freeb_resp_avail;
      assign dec           = rel_grant[gi];
      assign quota_err[gi] = err_reg;
      assign id_acc[gi+1]  = id_acc[gi] | (alloc_grant[gi] ? IDW'(gi) : '0);
      assign ptr_acc[gi+1] = ptr_acc[gi] |
                             (rel_grant[gi] ? rel_ptr[gi*BPTR_NBITS +: BPTR_NBITS] : '0);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pending_reg <= 1'b0;
          err_reg     <= 1'b0;
          held_reg    <= '0;
        end else begin
          if (alloc_grant[gi]) begin
            pending_reg <= 1'b1;
          end else if (ack[gi]) begin
            pending_reg <= 1'b0;
          end
          if (state_reg == ST_INIT_PULSE) begin
            held_reg <= '0;
          end else if (inc && !dec) begin
            held_reg <= held_reg + 1'b1;
          end else if (dec && !inc) begin
            // Releasing with nothing held is a client bug: flag it, never wrap.
            if (held_reg == '0) begin
              err_reg <= 1'b1;
            end else begin
              held_reg <= held_reg - 1'b1;
            end
          end
        end
      end
    end
  endgenerate

  edit_mem_rr_arb #(.N(NREQ)) u_alloc_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (elig),
    .advance (1'b1),
    .grant   (alloc_grant)
  );

  edit_mem_rr_arb #(.N(NREQ)) u_rel_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (rel_valid & {NREQ{rel_en}}),
    .advance (1'b1),
    .grant   (rel_grant)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_WAIT_DONE:  if (freeb_init_done) state_next = ST_RUN;
      ST_RUN:        if (sw_init) state_next = ST_DRAIN;
      ST_DRAIN:      if (!freeb_req_reg && (pipe_v == '0)) state_next = ST_INIT_PULSE;
      ST_INIT_PULSE: state_next = ST_WAIT_LOW;
      ST_WAIT_LOW:   if (!freeb_init_done) state_next = ST_WAIT_DONE;
      default:       state_next = ST_WAIT_DONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg           <= ST_WAIT_DONE;
      freeb_req_reg       <= 1'b0;
      req_id_reg          <= '0;
      pipe_reg            <= '0;
      freeb_rel_valid_reg <= 1'b0;
      freeb_rel_ptr_reg   <= '0;
    end else begin
      state_reg           <= state_next;
      freeb_req_reg       <= |alloc_grant;
      req_id_reg          <= id_acc[NREQ];
      pipe_reg            <= PIW'({pipe_reg, freeb_req_reg, req_id_reg});
      freeb_rel_valid_reg <= |rel_grant;
      freeb_rel_ptr_reg   <= ptr_acc[NREQ];
    end
  end

  assign rel_ready       = rel_grant;
  assign ack_ok          = resp_hit & freeb_resp_avail;
  assign ack_ptr         = resp_hit ? freeb_resp_ptr : '0;
  assign init_busy       = ~run;
  assign freeb_req       = freeb_req_reg;
  assign freeb_rel_valid = freeb_rel_valid_reg;
  assign freeb_rel_ptr   = freeb_rel_ptr_reg;
  assign freeb_init      = (state_reg == ST_INIT_PULSE);

  resp_has_tag: assert property (@(posedge clk) disable iff (rst) freeb_resp_valid |-> head_v);

endmodule

// File: tb/tb_edit_mem_freeb_arb.sv
// Randomised bench for edit_mem_freeb_arb: a pool responder plus a cycle-level
// reference model built from the allocation/release/re-init rules.
module tb_edit_mem_freeb_arb;
  localparam int NREQ   = 4;
  localparam int BW     = 8;
  localparam int LAT    = 3;
  localparam int QUOTA  = 16;
  localparam int POOL_N = 64;

  localparam int M_WAIT_DONE = 0, M_RUN = 1, M_DRAIN = 2, M_INIT_PULSE = 3, M_WAIT_LOW = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req, ack, rel_valid, rel_ready, quota_err;
  logic                 ack_ok, sw_init, init_busy, freeb_req;
  logic [BW-1:0]        ack_ptr, freeb_resp_ptr, freeb_rel_ptr;
  logic [NREQ*BW-1:0]   rel_ptr;
  logic                 freeb_resp_valid, freeb_resp_avail, freeb_rel_valid;
  logic                 freeb_init, freeb_init_done;

  always #5 clk = ~clk;

  edit_mem_freeb_arb #(
    .NREQ(NREQ), .BPTR_NBITS(BW), .FREEB_LAT(LAT), .QUOTA(QUOTA), .QNBITS(6)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .ack_ok(ack_ok), .ack_ptr(ack_ptr),
    .rel_valid(rel_valid), .rel_ptr(rel_ptr), .rel_ready(rel_ready), .sw_init(sw_init),
    .init_busy(init_busy), .quota_err(quota_err), .freeb_req(freeb_req),
    .freeb_resp_valid(freeb_resp_valid), .freeb_resp_avail(freeb_resp_avail),
    .freeb_resp_ptr(freeb_resp_ptr), .freeb_rel_valid(freeb_rel_valid),
    .freeb_rel_ptr(freeb_rel_ptr), .freeb_init(freeb_init), .freeb_init_done(freeb_init_done)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  // reference model
  int              m_state;
  int              m_held [NREQ];
  bit [NREQ-1:0]   m_pending, m_qerr;
  int              m_rr_a, m_rr_r;
  int              m_fl_id[$];
  int              m_fl_due[$];
  bit              exp_freeb_req, exp_rel_v;
  logic [BW-1:0]   exp_rel_ptr;

  // pool responder and requester-side bookkeeping
  int              pool_free[$];
  int              pool_due[$];
  int              low_from, low_until;
  int              owned [NREQ][$];
  bit [NREQ-1:0]   req_bits, req_mask, rel_mask, err_en;
  int              p_req, p_rel, p_empty, p_init;
  bit              force_init;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic run_cycle();
    bit [NREQ-1:0] exp_ack, exp_rdy;
    bit            exp_ok;
    logic [BW-1:0] exp_ptr;
    int            ack_id, g, r, nxt;
    bit            busy;

    @(posedge clk);
    #1;
    cyc++;
    check_val("freeb_req", freeb_req, exp_freeb_req);
    check_val("freeb_rel_valid", freeb_rel_valid, exp_rel_v);
    if (exp_rel_v) check_val("freeb_rel_ptr", freeb_rel_ptr, exp_rel_ptr);
    check_val("freeb_init", freeb_init, m_state == M_INIT_PULSE);
    check_val("init_busy", init_busy, m_state != M_RUN);
    check_val("quota_err", quota_err, m_qerr);

    // pool side
    if (freeb_req) pool_due.push_back(cyc + LAT);
    if (freeb_rel_valid) pool_free.push_back(int'(freeb_rel_ptr));
    if (freeb_init) begin
      pool_free.delete();
      for (int p = 0; p < POOL_N; p++) pool_free.push_back(p);
      low_from  = cyc + 1;
      low_until = cyc + 4;
    end
    freeb_resp_valid = 1'b0;
    freeb_resp_avail = 1'($urandom);
    freeb_resp_ptr   = BW'($urandom);
    if (pool_due.size() > 0 && pool_due[0] == cyc) begin
      void'(pool_due.pop_front());
      freeb_resp_valid = 1'b1;
      if (pool_free.size() > 0 && int'($urandom_range(99)) >= p_empty) begin
        freeb_resp_avail = 1'b1;
        freeb_resp_ptr   = BW'(pool_free.pop_front());
      end else begin
        freeb_resp_avail = 1'b0;
      end
    end
    freeb_init_done = !(cyc >= low_from && cyc <= low_until);

    // requesters
    for (int i = 0; i < NREQ; i++) begin
      if (!req_bits[i] && req_mask[i] && int'($urandom_range(99)) < p_req) req_bits[i] = 1'b1;
    end
    req = req_bits;
    rel_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      rel_ptr[i*BW +: BW] = BW'($urandom);
      if (rel_mask[i] && int'($urandom_range(99)) < p_rel) begin
        if (owned[i].size() > 0) begin
          rel_valid[i] = 1'b1;
          rel_ptr[i*BW +: BW] = BW'(owned[i][0]);
        end else if (err_en[i] && !m_pending[i]) begin
          rel_valid[i] = 1'b1;
        end
      end
    end
    sw_init = force_init || (int'($urandom_range(999)) < p_init);
    #1;

    // expected combinational responses
    exp_ack = '0;
    ack_id  = -1;
    if (m_fl_due.size() > 0 && m_fl_due[0] == cyc) begin
      ack_id = m_fl_id[0];
      exp_ack[ack_id] = 1'b1;
    end
    exp_ok  = (ack_id >= 0) && freeb_resp_avail;
    exp_ptr = (ack_id >= 0) ? freeb_resp_ptr : '0;
    check_val("ack", ack, exp_ack);
    check_val("ack_ok", ack_ok, exp_ok);
    check_val("ack_ptr", ack_ptr, exp_ptr);

    r = -1;
    if (m_state == M_RUN || m_state == M_DRAIN) begin
      for (int k = 0; k < NREQ; k++) begin
        if (r < 0 && rel_valid[(m_rr_r + k) % NREQ]) r = (m_rr_r + k) % NREQ;
      end
    end
    exp_rdy = '0;
    if (r >= 0) exp_rdy[r] = 1'b1;
    check_val("rel_ready", rel_ready, exp_rdy);

    g = -1;
    if (m_state == M_RUN) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_rr_a + k) % NREQ;
        if (g < 0 && req[i] && !m_pending[i] && m_held[i] < QUOTA) g = i;
      end
    end

    // advance the model across the clock edge
    busy = (m_fl_id.size() > 0);
    nxt  = m_state;
    case (m_state)
      M_WAIT_DONE:  if (freeb_init_done) nxt = M_RUN;
      M_RUN:        if (sw_init) nxt = M_DRAIN;
      M_DRAIN:      if (!busy) nxt = M_INIT_PULSE;
      M_INIT_PULSE: nxt = M_WAIT_LOW;
      default:      if (!freeb_init_done) nxt = M_WAIT_DONE;
    endcase

    exp_freeb_req = (g >= 0);
    if (g >= 0) begin
      m_pending[g] = 1'b1;
      m_fl_id.push_back(g);
      m_fl_due.push_back(cyc + 1 + LAT);
      m_rr_a = (g + 1) % NREQ;
    end
    exp_rel_v = (r >= 0);
    if (r >= 0) begin
      exp_rel_ptr = rel_ptr[r*BW +: BW];
      m_rr_r = (r + 1) % NREQ;
    end
    if (ack_id >= 0) begin
      void'(m_fl_id.pop_front());
      void'(m_fl_due.pop_front());
      m_pending[ack_id] = 1'b0;
      req_bits[ack_id]  = 1'b0;
    end

    if (m_state == M_INIT_PULSE) begin
      for (int i = 0; i < NREQ; i++) begin
        m_held[i] = 0;
        owned[i].delete();
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        bit inc, dec;
        inc = (ack_id == i) && exp_ok;
        dec = (r == i);
        if (dec && owned[i].size() > 0) void'(owned[i].pop_front());
        if (inc) owned[i].push_back(int'(exp_ptr));
        if (inc && !dec) m_held[i]++;
        else if (dec && !inc) begin
          if (m_held[i] > 0) m_held[i]--;
          else m_qerr[i] = 1'b1;
        end
      end
    end
    m_state = nxt;
  endtask

  task automatic run_n(input int n);
    for (int c = 0; c < n; c++) run_cycle();
  endtask

  initial begin
    rst = 1'b1;
    req = '1;
    rel_valid = '1;
    rel_ptr = '0;
    sw_init = 1'b0;
    freeb_resp_valid = 1'b0;
    freeb_resp_avail = 1'b0;
    freeb_resp_ptr = '0;
    freeb_init_done = 1'b0;

    m_state = M_WAIT_DONE;
    m_pending = '0;
    m_qerr = '0;
    m_rr_a = 0;
    m_rr_r = 0;
    exp_freeb_req = 1'b0;
    exp_rel_v = 1'b0;
    exp_rel_ptr = '0;
    for (int i = 0; i < NREQ; i++) m_held[i] = 0;
    for (int p = 0; p < POOL_N; p++) pool_free.push_back(p);
    low_from = 0;
    low_until = 4;
    req_bits = '0;
    req_mask = '0;
    rel_mask = '0;
    err_en = '0;
    p_req = 0;
    p_rel = 0;
    p_empty = 0;
    p_init = 0;
    force_init = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_init_busy", init_busy, 1'b1);
    check_val("rst_freeb_req", freeb_req, 1'b0);
    check_val("rst_ack", ack, '0);
    check_val("rst_rel_ready", rel_ready, '0);
    check_val("rst_freeb_init", freeb_init, 1'b0);
    check_val("rst_freeb_rel_valid", freeb_rel_valid, 1'b0);
    check_val("rst_quota_err", quota_err, '0);
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    rel_valid = '0;

    // pool comes up at cycle 5, single request from PU0
    run_n(5);
    req_bits = 4'b0001;
    run_n(10);

    // all four requesting continuously
    req_mask = 4'b1111;
    p_req = 100;
    run_n(20);

    // PU2 runs into its quota, then one release reopens it
    req_mask = 4'b0100;
    run_n(100);
    rel_mask = 4'b0100;
    p_rel = 100;
    run_n(1);
    rel_mask = '0;
    run_n(12);

    // pool reports empty
    req_mask = 4'b1111;
    p_empty = 100;
    run_n(20);
    p_empty = 0;

    // PU1 releases past zero; PU0 allocates while releasing
    req_mask = '0;
    rel_mask = 4'b0010;
    err_en = 4'b0010;
    run_n(30);
    req_mask = 4'b0001;
    rel_mask = 4'b0001;
    err_en = '0;
    run_n(30);

    // re-init with allocations in flight
    rel_mask = '0;
    req_mask = 4'b1111;
    run_n(3);
    force_init = 1'b1;
    run_n(1);
    force_init = 1'b0;
    run_n(30);

    // random mix
    req_mask = 4'b1111;
    rel_mask = 4'b1111;
    p_req = 40;
    p_rel = 30;
    p_empty = 10;
    p_init = 3;
    run_n(1500);
    err_en = 4'b1111;
    run_n(1500);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
